mdu_param: RTL

// - Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core; sits in the E stage beside the ALU.
// - Multi-cycle MULT/DIV with configurable latency; start/busy handshake drives the conflict unit's MDU stall (stall while start|busy).
// - Honours the CP0 interrupt/exception request so no HI/LO side effect occurs for a squashed instruction.

---
 rtl/mdu_param_if.sv | 26 ++
 rtl/mdu_param.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mdu_param_if.sv
// mdu_param_if: E-stage request/response bundle between the core and the multiply/divide unit.
// master = core side, slave = mdu_param.
interface mdu_param_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             req;
  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;

  modport master (
    output req, op_valid, op, rs, rt,
    input  start, busy, hi, lo, mf_data
  );

  modport slave (
    input  req, op_valid, op, rs, rt,
    output start, busy, hi, lo, mf_data
  );
endinterface

// File: rtl/mdu_param.sv
// mdu_param: multi-cycle MULT/DIV unit with HI/LO registers and start/busy stall handshake.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 9-12).
module mdu_param #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_param_if.slave bus
);
  localparam int unsigned W2      = 2 * WIDTH;
  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state;
  logic             busy_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q, shadow_hi, shadow_lo;

  logic             is_mul, is_div, is_acc, signed_op, accept, start_c;
  logic [W2-1:0]    ext_rs, ext_rt, prod;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] mag_rs, mag_rt, div_den, q_mag, r_mag, quo, rem;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Opcode decode
  always_comb begin
    is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_acc    = 1'b0;
`ifdef MDU_MADD_EN
    is_acc    = (bus.op == OP_MADD) || (bus.op == OP_MADDU) ||
                (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
    signed_op = signed_op || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
`endif
  end

  assign accept  = bus.op_valid && !busy_q && !bus.req;
  assign start_c = accept && (is_mul || is_div || is_acc);

  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both signednesses
  assign ext_rs = signed_op ? {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs} : {{WIDTH{1'b0}}, bus.rs};
  assign ext_rt = signed_op ? {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt} : {{WIDTH{1'b0}}, bus.rt};
  assign prod   = ext_rs * ext_rt;

  // Magnitude divide; min/-1 wraps back to min naturally after re-negation
  assign rs_neg  = signed_op && bus.rs[WIDTH-1];
  assign rt_neg  = signed_op && bus.rt[WIDTH-1];
  assign mag_rs  = rs_neg ? -bus.rs : bus.rs;
  assign mag_rt  = rt_neg ? -bus.rt : bus.rt;
  assign div_den = (bus.rt == '0) ? WIDTH'(1) : mag_rt;
  assign q_mag   = mag_rs / div_den;
  assign r_mag   = mag_rs % div_den;
  assign quo     = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
  assign rem     = rs_neg ? -r_mag : r_mag;

  // Result captured into the shadow registers at accept
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    if (is_div) begin
      if (bus.rt == '0) begin
        res_hi = bus.rs;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end else if (is_mul) begin
      {res_hi, res_lo} = prod;
    end
`ifdef MDU_MADD_EN
    else if (is_acc) begin
      if ((bus.op == OP_MSUB) || (bus.op == OP_MSUBU))
        {res_hi, res_lo} = {hi_q, lo_q} - prod;
      else
        {res_hi, res_lo} = {hi_q, lo_q} + prod;
    end
`endif
  end

  // Control FSM with HI/LO and shadow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy_q    <= 1'b0;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_c) begin
            state     <= S_RUN;
            busy_q    <= 1'b1;
            cnt       <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            shadow_hi <= res_hi;
            shadow_lo <= res_lo;
          end else if (accept && (bus.op == OP_MTHI)) begin
            hi_q <= bus.rs;
          end else if (accept && (bus.op == OP_MTLO)) begin
            lo_q <= bus.rs;
          end
        end
        S_RUN: begin
          if (cnt == CW'(1)) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            hi_q   <= shadow_hi;
            lo_q   <= shadow_lo;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.start   = start_c;
  assign bus.busy    = busy_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mf_data = (bus.op == OP_MFHI) ? hi_q : lo_q;
endmodule
